// File: rtl/memory_arbiter_rr_if.sv
// rtl/memory_arbiter_rr_if.sv - cache-side and RAM-side bus bundle for memory_arbiter_rr
// Per-core vectors are packed with core c at [c*W +: W].
interface memory_arbiter_rr_if #(
  parameter int CPUS   = 2,
  parameter int ADDR_W = 32,
  parameter int WORD_W = 32
);
  logic [CPUS-1:0]        iREN;
  logic [CPUS-1:0]        dREN;
  logic [CPUS-1:0]        dWEN;
  logic [CPUS*ADDR_W-1:0] iaddr;
  logic [CPUS*ADDR_W-1:0] daddr;
  logic [CPUS*WORD_W-1:0] dstore;
  logic [CPUS-1:0]        iwait;
  logic [CPUS-1:0]        dwait;
  logic [CPUS*WORD_W-1:0] iload;
  logic [CPUS*WORD_W-1:0] dload;
  logic [1:0]             ramstate;
  logic [WORD_W-1:0]      ramload;
  logic [ADDR_W-1:0]      ramaddr;
  logic [WORD_W-1:0]      ramstore;
  logic                   ramREN;
  logic                   ramWEN;

  // Arbiter view: masters the RAM port, serves the caches.
  modport master (
    input  iREN, dREN, dWEN, iaddr, daddr, dstore, ramstate, ramload,
    output iwait, dwait, iload, dload, ramaddr, ramstore, ramREN, ramWEN
  );

  // Environment view: caches plus RAM model.
  modport slave (
    output iREN, dREN, dWEN, iaddr, daddr, dstore, ramstate, ramload,
    input  iwait, dwait, iload, dload, ramaddr, ramstore, ramREN, ramWEN
  );
endinterface

// File: rtl/memory_arbiter_rr.sv
// rtl/memory_arbiter_rr.sv - round-robin arbiter of per-core I/D cache requests onto one RAM port
// Optional feature macro: MEMARB_STATS_EN adds the grant_cnt port with saturating per-core
// completion counters; when undefined the port and counters are absent.
// ramstate encoding: 0 FREE, 1 BUSY, 2 ACCESS, 3 ERROR.
module memory_arbiter_rr #(
  parameter int CPUS   = 2,
  parameter int ADDR_W = 32,
  parameter int WORD_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic                   CLK,
  input  logic                   nRST,
  memory_arbiter_rr_if.master    bus
`ifdef MEMARB_STATS_EN
  ,
  output logic [CPUS*CNT_W-1:0]  grant_cnt
`endif
);

  localparam int PTR_W = (CPUS > 1) ? $clog2(CPUS) : 1;

  localparam logic [1:0] RAM_ACCESS = 2'd2;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t           state;
  logic [PTR_W-1:0] rr_ptr;
  logic [PTR_W-1:0] g_core;
  logic             g_data;
  logic             g_write;

  logic [CPUS-1:0]  d_act;
  logic [CPUS-1:0]  i_act;
  logic [CPUS-1:0]  cls_act;
  logic             any_d;
  logic             any_i;
  logic [PTR_W-1:0] win_core;
  logic             win_found;
  int               sel_idx;
  logic [PTR_W-1:0] next_ptr;
  logic             g_active;
  logic             completing;

  // Requester activity: a data requester is active on either read or write enable.
  always_comb begin
    d_act = bus.dREN | bus.dWEN;
    i_act = bus.iREN;
    any_d = |d_act;
    any_i = |i_act;
  end

  // Winner search: data class beats instruction class; within the class, first active
  // core at or above the round-robin pointer, wrapping past CPUS-1 back to 0.
  always_comb begin
    cls_act   = any_d ? d_act : i_act;
    win_core  = '0;
    win_found = 1'b0;
    sel_idx   = 0;
    for (int k = 0; k < CPUS; k++) begin
      sel_idx = int'(rr_ptr) + k;
      if (sel_idx >= CPUS) begin
        sel_idx = sel_idx - CPUS;
      end
      if (!win_found && cls_act[sel_idx]) begin
        win_found = 1'b1;
        win_core  = PTR_W'(sel_idx);
      end
    end
  end

  // Granted requester still holding its enable, and whether this cycle finishes its access.
  always_comb begin
    g_active   = g_data ? d_act[g_core] : i_act[g_core];
    completing = (state == GRANT) && g_active && (bus.ramstate == RAM_ACCESS);
    next_ptr   = (int'(g_core) == CPUS - 1) ? '0 : g_core + PTR_W'(1);
  end

  // Arbitration FSM: latch the winner in IDLE, hold it in GRANT until ACCESS or abort.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state   <= IDLE;
      rr_ptr  <= '0;
      g_core  <= '0;
      g_data  <= 1'b0;
      g_write <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (any_d || any_i) begin
            g_core  <= win_core;
            g_data  <= any_d;
            g_write <= any_d & bus.dWEN[win_core];
            state   <= GRANT;
          end
        end
        GRANT: begin
          if (!g_active) begin
            // Requester withdrew: drop the grant, leave fairness pointer alone.
            state <= IDLE;
          end else if (bus.ramstate == RAM_ACCESS) begin
            rr_ptr <= next_ptr;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // RAM port and wait lines follow the granted requester's live address/data; the wait of
  // that requester drops only in the ACCESS cycle, every other wait stays high.
  always_comb begin
    bus.iwait    = '1;
    bus.dwait    = '1;
    bus.ramaddr  = '0;
    bus.ramstore = '0;
    bus.ramREN   = 1'b0;
    bus.ramWEN   = 1'b0;
    if (state == GRANT && g_active) begin
      if (g_data) begin
        bus.ramaddr  = bus.daddr[int'(g_core)*ADDR_W +: ADDR_W];
        bus.ramstore = bus.dstore[int'(g_core)*WORD_W +: WORD_W];
      end else begin
        bus.ramaddr  = bus.iaddr[int'(g_core)*ADDR_W +: ADDR_W];
      end
      bus.ramWEN = g_data & g_write;
      bus.ramREN = ~(g_data & g_write);
      if (bus.ramstate == RAM_ACCESS) begin
        if (g_data) begin
          bus.dwait[g_core] = 1'b0;
        end else begin
          bus.iwait[g_core] = 1'b0;
        end
      end
    end
  end

  // Read data is broadcast; each core qualifies it with its own wait line.
  always_comb begin
    bus.iload = {CPUS{bus.ramload}};
    bus.dload = {CPUS{bus.ramload}};
  end

`ifdef MEMARB_STATS_EN
  logic [CNT_W-1:0] cnt_q [CPUS];

  // Per-core completion counters; stick at all-ones instead of wrapping.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int c = 0; c < CPUS; c++) begin
        cnt_q[c] <= '0;
      end
    end else if (completing && (cnt_q[g_core] != {CNT_W{1'b1}})) begin
      cnt_q[g_core] <= cnt_q[g_core] + CNT_W'(1);
    end
  end

  // Flatten counters onto the packed output, core c at [c*CNT_W +: CNT_W].
  always_comb begin
    grant_cnt = '0;
    for (int c = 0; c < CPUS; c++) begin
      grant_cnt[c*CNT_W +: CNT_W] = cnt_q[c];
    end
  end
`else
  logic unused_stats;
  assign unused_stats = (CNT_W > 0) & completing;
`endif

endmodule

// File: tb/tb_memory_arbiter_rr.sv
// tb/tb_memory_arbiter_rr.sv - self-checking bench for memory_arbiter_rr
module tb_memory_arbiter_rr;
  localparam int CPUS   = 4;
  localparam int ADDR_W = 32;
  localparam int WORD_W = 32;
  localparam int CNT_W  = 2;

  localparam logic [1:0] FREE   = 2'd0;
  localparam logic [1:0] BUSY   = 2'd1;
  localparam logic [1:0] ACCESS = 2'd2;
  localparam logic [1:0] ERROR  = 2'd3;

  logic CLK = 1'b0;
  logic nRST;
  int   passed = 0;
  int   total  = 0;

  always #5 CLK = ~CLK;

  memory_arbiter_rr_if #(.CPUS(CPUS), .ADDR_W(ADDR_W), .WORD_W(WORD_W)) bus ();

`ifdef MEMARB_STATS_EN
  logic [CPUS*CNT_W-1:0] grant_cnt;
`endif

  memory_arbiter_rr #(
    .CPUS(CPUS), .ADDR_W(ADDR_W), .WORD_W(WORD_W), .CNT_W(CNT_W)
  ) dut (
    .CLK(CLK),
    .nRST(nRST),
    .bus(bus)
`ifdef MEMARB_STATS_EN
    ,
    .grant_cnt(grant_cnt)
`endif
  );

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic clear_inputs();
    bus.iREN     = '0;
    bus.dREN     = '0;
    bus.dWEN     = '0;
    bus.iaddr    = '0;
    bus.daddr    = '0;
    bus.dstore   = '0;
    bus.ramstate = FREE;
    bus.ramload  = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    nRST = 1'b0;
    @(posedge CLK);
    @(posedge CLK);
    #1;
    nRST = 1'b1;
  endtask

  task automatic test_reset();
    clear_inputs();
    nRST = 1'b0;
    bus.iREN = '1;
    bus.dREN = '1;
    bus.ramstate = ACCESS;
    @(posedge CLK);
    @(negedge CLK);
    total++; if (bus.iwait !== 4'hF) $display("FAIL reset_iwait got=%b exp=1111", bus.iwait); else passed++;
    total++; if (bus.dwait !== 4'hF) $display("FAIL reset_dwait got=%b exp=1111", bus.dwait); else passed++;
    total++; if (bus.ramREN !== 1'b0 || bus.ramWEN !== 1'b0)
      $display("FAIL reset_en got REN=%b WEN=%b exp=0 0", bus.ramREN, bus.ramWEN); else passed++;
    total++; if (bus.ramaddr !== '0 || bus.ramstore !== '0)
      $display("FAIL reset_bus got addr=%h store=%h exp=0 0", bus.ramaddr, bus.ramstore); else passed++;
    do_reset();
  endtask

  task automatic test_single_iread();
    do_reset();
    bus.iREN[0] = 1'b1;
    bus.iaddr[31:0] = 32'h40;
    @(negedge CLK);
    total++; if (bus.iwait !== 4'hF || bus.ramREN !== 1'b0)
      $display("FAIL iread_idle got iwait=%b REN=%b exp=1111 0", bus.iwait, bus.ramREN); else passed++;
    for (int b = 0; b < 2; b++) begin
      tick();
      bus.ramstate = BUSY;
      @(negedge CLK);
      total++; if (bus.ramaddr !== 32'h40 || bus.ramREN !== 1'b1 || bus.iwait !== 4'hF)
        $display("FAIL iread_busy%0d got addr=%h REN=%b iwait=%b exp=40 1 1111", b, bus.ramaddr, bus.ramREN, bus.iwait);
      else passed++;
    end
    tick();
    bus.ramstate = ACCESS;
    bus.ramload  = 32'hDEADBEEF;
    @(negedge CLK);
    total++; if (bus.iwait !== 4'b1110) $display("FAIL iread_access got iwait=%b exp=1110", bus.iwait); else passed++;
    total++; if (bus.iload[31:0] !== 32'hDEADBEEF) $display("FAIL iread_load got=%h exp=deadbeef", bus.iload[31:0]); else passed++;
    tick();
    bus.iREN = '0;
    bus.ramstate = FREE;
    @(negedge CLK);
    total++; if (bus.iwait !== 4'hF || bus.ramREN !== 1'b0)
      $display("FAIL iread_after got iwait=%b REN=%b exp=1111 0", bus.iwait, bus.ramREN); else passed++;
  endtask

  task automatic test_data_priority();
    do_reset();
    bus.iREN[0] = 1'b1;
    bus.iaddr[31:0] = 32'h100;
    bus.dWEN[1] = 1'b1;
    bus.daddr[63:32] = 32'h200;
    bus.dstore[63:32] = 32'h55AA;
    tick();
    bus.ramstate = ACCESS;
    @(negedge CLK);
    total++; if (bus.ramWEN !== 1'b1 || bus.ramREN !== 1'b0 || bus.ramaddr !== 32'h200 || bus.ramstore !== 32'h55AA)
      $display("FAIL prio_write got WEN=%b REN=%b addr=%h store=%h exp=1 0 200 55aa",
               bus.ramWEN, bus.ramREN, bus.ramaddr, bus.ramstore);
    else passed++;
    total++; if (bus.dwait !== 4'b1101 || bus.iwait !== 4'hF)
      $display("FAIL prio_waits got dwait=%b iwait=%b exp=1101 1111", bus.dwait, bus.iwait); else passed++;
    tick();
    bus.dWEN = '0;
    bus.ramstate = FREE;
    @(negedge CLK);
    total++; if (bus.ramREN !== 1'b0 || bus.ramWEN !== 1'b0)
      $display("FAIL prio_bubble got REN=%b WEN=%b exp=0 0", bus.ramREN, bus.ramWEN); else passed++;
    tick();
    bus.ramstate = ACCESS;
    @(negedge CLK);
    total++; if (bus.ramaddr !== 32'h100 || bus.ramREN !== 1'b1 || bus.iwait !== 4'b1110)
      $display("FAIL prio_iread got addr=%h REN=%b iwait=%b exp=100 1 1110", bus.ramaddr, bus.ramREN, bus.iwait);
    else passed++;
    tick();
    clear_inputs();
  endtask

  task automatic test_back_to_back();
    logic [CPUS-1:0] exp_dw;
    do_reset();
    bus.dREN = '1;
    for (int c = 0; c < CPUS; c++) bus.daddr[c*ADDR_W +: ADDR_W] = 32'h1000 + 32'(c * 4);
    bus.ramstate = ACCESS;
    for (int g = 0; g < 5; g++) begin
      tick();
      @(negedge CLK);
      exp_dw = '1;
      exp_dw[g % CPUS] = 1'b0;
      total++; if (bus.ramaddr !== 32'h1000 + 32'((g % CPUS) * 4) || bus.dwait !== exp_dw)
        $display("FAIL rr_grant%0d got addr=%h dwait=%b exp=%h %b", g, bus.ramaddr, bus.dwait,
                 32'h1000 + 32'((g % CPUS) * 4), exp_dw);
      else passed++;
      tick();
      @(negedge CLK);
      total++; if (bus.ramREN !== 1'b0 || bus.dwait !== 4'hF)
        $display("FAIL rr_bubble%0d got REN=%b dwait=%b exp=0 1111", g, bus.ramREN, bus.dwait); else passed++;
    end
    clear_inputs();
  endtask

  task automatic test_abort();
    do_reset();
    for (int c = 0; c < CPUS; c++) bus.daddr[c*ADDR_W +: ADDR_W] = 32'h2000 + 32'(c * 16);
    bus.dREN[0] = 1'b1;
    bus.ramstate = ACCESS;
    tick();
    @(negedge CLK);
    total++; if (bus.dwait !== 4'b1110) $display("FAIL abort_pre got dwait=%b exp=1110", bus.dwait); else passed++;
    tick();
    bus.dREN = 4'b0100;
    bus.ramstate = FREE;
    tick();
    bus.ramstate = BUSY;
    @(negedge CLK);
    total++; if (bus.ramREN !== 1'b1 || bus.ramaddr !== 32'h2020)
      $display("FAIL abort_grant got REN=%b addr=%h exp=1 2020", bus.ramREN, bus.ramaddr); else passed++;
    tick();
    bus.dREN = '0;
    @(negedge CLK);
    total++; if (bus.dwait !== 4'hF || bus.ramREN !== 1'b0)
      $display("FAIL abort_drop got dwait=%b REN=%b exp=1111 0", bus.dwait, bus.ramREN); else passed++;
    tick();
    bus.dREN = 4'b0011;
    bus.ramstate = ACCESS;
    @(negedge CLK);
    total++; if (bus.ramREN !== 1'b0) $display("FAIL abort_idle got REN=%b exp=0", bus.ramREN); else passed++;
    tick();
    @(negedge CLK);
    total++; if (bus.dwait !== 4'b1101 || bus.ramaddr !== 32'h2010)
      $display("FAIL abort_ptr got dwait=%b addr=%h exp=1101 2010", bus.dwait, bus.ramaddr); else passed++;
    tick();
    clear_inputs();
  endtask

  task automatic test_error_retry();
    do_reset();
    bus.dREN[3] = 1'b1;
    bus.daddr[127:96] = 32'h3000;
    tick();
    bus.ramstate = ERROR;
    for (int e = 0; e < 3; e++) begin
      @(negedge CLK);
      total++; if (bus.dwait !== 4'hF || bus.ramREN !== 1'b1)
        $display("FAIL err_hold%0d got dwait=%b REN=%b exp=1111 1", e, bus.dwait, bus.ramREN); else passed++;
      tick();
    end
    bus.ramstate = ACCESS;
    @(negedge CLK);
    total++; if (bus.dwait !== 4'b0111) $display("FAIL err_access got dwait=%b exp=0111", bus.dwait); else passed++;
    tick();
    bus.dREN = '0;
    bus.ramstate = FREE;
    @(negedge CLK);
    total++; if (bus.dwait !== 4'hF) $display("FAIL err_after got dwait=%b exp=1111", bus.dwait); else passed++;
  endtask

  task automatic test_async_reset();
    do_reset();
    bus.iREN[1] = 1'b1;
    bus.iaddr[63:32] = 32'h4444;
    tick();
    bus.ramstate = BUSY;
    @(negedge CLK);
    total++; if (bus.ramREN !== 1'b1) $display("FAIL areset_pre got REN=%b exp=1", bus.ramREN); else passed++;
    #2;
    nRST = 1'b0;
    #1;
    total++; if (bus.ramREN !== 1'b0 || bus.iwait !== 4'hF)
      $display("FAIL areset_now got REN=%b iwait=%b exp=0 1111", bus.ramREN, bus.iwait); else passed++;
    bus.ramstate = ACCESS;
    @(negedge CLK);
    total++; if (bus.iwait !== 4'hF) $display("FAIL areset_hold got iwait=%b exp=1111", bus.iwait); else passed++;
    do_reset();
  endtask

`ifdef MEMARB_STATS_EN
  task automatic test_stats();
    int n_done;
    int exp_c;
    do_reset();
    n_done = 0;
    bus.iREN[0] = 1'b1;
    bus.ramstate = ACCESS;
    for (int t = 0; t < 5; t++) begin
      tick();
      tick();
      n_done++;
      exp_c = (n_done > 3) ? 3 : n_done;
      @(negedge CLK);
      total++; if (grant_cnt[CNT_W-1:0] !== CNT_W'(exp_c))
        $display("FAIL stats_cnt%0d got=%0d exp=%0d", n_done, grant_cnt[CNT_W-1:0], exp_c); else passed++;
    end
    total++; if (grant_cnt[CPUS*CNT_W-1:CNT_W] !== '0)
      $display("FAIL stats_others got=%h exp=0", grant_cnt[CPUS*CNT_W-1:CNT_W]); else passed++;
    clear_inputs();
  endtask
`endif

  // Transaction-level reference: winner chosen from the request snapshot by the priority
  // and rotation rules, then the whole RAM handshake is predicted cycle by cycle.
  task automatic test_random();
    logic [CPUS-1:0]   ir, dr, dw;
    logic [ADDR_W-1:0] ia [CPUS];
    logic [ADDR_W-1:0] da [CPUS];
    logic [WORD_W-1:0] ds [CPUS];
    logic [CPUS-1:0]   exp_iw, exp_dw;
    logic [ADDR_W-1:0] exp_addr;
    logic [WORD_W-1:0] exp_store, rl;
    logic              data_cls, wr, drop, aborted;
    int                ptr, win, n_hold, drop_at;
    do_reset();
    ptr = 0;
    for (int t = 0; t < 80; t++) begin
      ir = CPUS'($urandom_range(0, (1 << CPUS) - 1));
      dr = CPUS'($urandom_range(0, (1 << CPUS) - 1));
      dw = CPUS'($urandom_range(0, (1 << CPUS) - 1));
      if ($urandom_range(0, 3) == 0) begin dr = '0; dw = '0; end
      if ($urandom_range(0, 9) == 0) ir = '0;
      for (int c = 0; c < CPUS; c++) begin
        ia[c] = $urandom; da[c] = $urandom; ds[c] = $urandom;
        bus.iaddr[c*ADDR_W +: ADDR_W]  = ia[c];
        bus.daddr[c*ADDR_W +: ADDR_W]  = da[c];
        bus.dstore[c*WORD_W +: WORD_W] = ds[c];
      end
      bus.iREN = ir; bus.dREN = dr; bus.dWEN = dw;
      bus.ramstate = FREE;
      @(negedge CLK);
      total++; if (bus.ramREN !== 1'b0 || bus.ramWEN !== 1'b0 || bus.iwait !== 4'hF || bus.dwait !== 4'hF)
        $display("FAIL rand_idle t=%0d got REN=%b WEN=%b iwait=%b dwait=%b exp=0 0 1111 1111",
                 t, bus.ramREN, bus.ramWEN, bus.iwait, bus.dwait);
      else passed++;
      tick();
      if ((ir | dr | dw) == '0) continue;

      data_cls = |(dr | dw);
      win = -1;
      for (int k = 0; k < CPUS; k++) begin
        int c;
        c = (ptr + k) % CPUS;
        if (win < 0 && (data_cls ? (dr[c] | dw[c]) : ir[c])) win = c;
      end
      wr        = data_cls && dw[win];
      exp_addr  = data_cls ? da[win] : ia[win];
      exp_store = data_cls ? ds[win] : '0;
      n_hold    = $urandom_range(0, 3);
      drop      = ($urandom_range(0, 5) == 0);
      drop_at   = $urandom_range(0, n_hold);
      aborted   = 1'b0;

      for (int h = 0; h <= n_hold && !aborted; h++) begin
        exp_iw = '1;
        exp_dw = '1;
        if (drop && h == drop_at) begin
          if (data_cls) begin dr[win] = 1'b0; dw[win] = 1'b0; end else ir[win] = 1'b0;
          bus.iREN = ir; bus.dREN = dr; bus.dWEN = dw;
          bus.ramstate = 2'($urandom_range(0, 3));
          @(negedge CLK);
          total++; if (bus.ramREN !== 1'b0 || bus.ramWEN !== 1'b0 || bus.iwait !== exp_iw || bus.dwait !== exp_dw)
            $display("FAIL rand_abort t=%0d got REN=%b WEN=%b iwait=%b dwait=%b exp=0 0 1111 1111",
                     t, bus.ramREN, bus.ramWEN, bus.iwait, bus.dwait);
          else passed++;
          aborted = 1'b1;
        end else begin
          if (h < n_hold) begin
            case ($urandom_range(0, 2))
              0: bus.ramstate = FREE;
              1: bus.ramstate = BUSY;
              default: bus.ramstate = ERROR;
            endcase
          end else begin
            bus.ramstate = ACCESS;
            rl = $urandom;
            bus.ramload = rl;
            if (data_cls) exp_dw[win] = 1'b0; else exp_iw[win] = 1'b0;
          end
          @(negedge CLK);
          total++; if (bus.ramaddr !== exp_addr || bus.ramstore !== exp_store || bus.ramREN !== !wr || bus.ramWEN !== wr)
            $display("FAIL rand_ram t=%0d h=%0d got addr=%h store=%h REN=%b WEN=%b exp=%h %h %b %b",
                     t, h, bus.ramaddr, bus.ramstore, bus.ramREN, bus.ramWEN, exp_addr, exp_store, !wr, wr);
          else passed++;
          total++; if (bus.iwait !== exp_iw || bus.dwait !== exp_dw)
            $display("FAIL rand_wait t=%0d h=%0d got iwait=%b dwait=%b exp=%b %b",
                     t, h, bus.iwait, bus.dwait, exp_iw, exp_dw);
          else passed++;
          if (h == n_hold) begin
            total++; if (bus.dload[win*WORD_W +: WORD_W] !== rl || bus.iload[win*WORD_W +: WORD_W] !== rl)
              $display("FAIL rand_load t=%0d got d=%h i=%h exp=%h", t,
                       bus.dload[win*WORD_W +: WORD_W], bus.iload[win*WORD_W +: WORD_W], rl);
            else passed++;
            ptr = (win + 1) % CPUS;
          end
        end
        tick();
      end
    end
    clear_inputs();
  endtask

  initial begin
    nRST = 1'b0;
    clear_inputs();
    test_reset();
    test_single_iread();
    test_data_priority();
    test_back_to_back();
    test_abort();
    test_error_retry();
    test_async_reset();
`ifdef MEMARB_STATS_EN
    test_stats();
`endif
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
